// File: rtl/rc5_encryptor.sv
// rc5_encryptor: RC5-W/R block encryptor. Reads the expanded key table S one
// word per two cycles over a synchronous-read memory port and returns the
// ciphertext with a one-cycle done pulse.
// Optional feature macro: RC5_ENC_DECRYPT_EN (adds iDecrypt and inverse rounds).
module rc5_encryptor #(
  parameter int unsigned W = 32,
  parameter int unsigned R = 12,
  localparam int unsigned T = 2 * R + 2,
  localparam int unsigned T_LENGTH = $clog2(T),
  localparam int unsigned ROTVALUE = $clog2(W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
`ifdef RC5_ENC_DECRYPT_EN
  input  logic                iDecrypt,
`endif
  input  logic [W-1:0]        iPlainA,
  input  logic [W-1:0]        iPlainB,
  output logic [T_LENGTH-1:0] oS_address,
  input  logic [W-1:0]        iS_sub_i,
  output logic [W-1:0]        oCipherA,
  output logic [W-1:0]        oCipherB,
  output logic                oBusy,
  output logic                oDone
);

  typedef enum logic [1:0] {StIdle, StWaitS, StCompute} state_e;

  localparam logic [T_LENGTH-1:0] LastIdx = T_LENGTH'(T - 1);

  state_e              state_q, state_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d;
  logic [W-1:0]        ca_q, ca_d, cb_q, cb_d;
  logic [T_LENGTH-1:0] idx_q, idx_d, addr_q, addr_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [W-1:0]        a_new, b_new;
  logic [T_LENGTH-1:0] step_idx;
  logic                first_pair, last_idx;
`ifdef RC5_ENC_DECRYPT_EN
  logic                dec_q, dec_d;
`endif

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [ROTVALUE-1:0] n);
    logic [2*W-1:0] d;
    d = {x, x} << n;
    return d[2*W-1:W];
  endfunction

`ifdef RC5_ENC_DECRYPT_EN
  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [ROTVALUE-1:0] n);
    logic [2*W-1:0] d;
    d = {x, x} >> n;
    return d[W-1:0];
  endfunction
`endif

  // Round datapath: candidate A/B for the current idx plus idx sequencing
  always_comb begin
    first_pair = (idx_q[T_LENGTH-1:1] == '0);
    a_new      = first_pair ? a_q + iS_sub_i
                            : rotl(a_q ^ b_q, b_q[ROTVALUE-1:0]) + iS_sub_i;
    b_new      = first_pair ? b_q + iS_sub_i
                            : rotl(b_q ^ a_q, a_q[ROTVALUE-1:0]) + iS_sub_i;
    last_idx   = (idx_q == LastIdx);
    step_idx   = idx_q + 1'b1;
`ifdef RC5_ENC_DECRYPT_EN
    if (dec_q) begin
      a_new    = first_pair ? a_q - iS_sub_i
                            : rotr(a_q - iS_sub_i, b_q[ROTVALUE-1:0]) ^ b_q;
      b_new    = first_pair ? b_q - iS_sub_i
                            : rotr(b_q - iS_sub_i, a_q[ROTVALUE-1:0]) ^ a_q;
      last_idx = (idx_q == '0);
      step_idx = idx_q - 1'b1;
    end
`endif
  end

  // Next-state logic: IDLE -> (WAIT_S -> COMPUTE) x T -> IDLE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef RC5_ENC_DECRYPT_EN
    dec_d   = dec_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          a_d     = iPlainA;
          b_d     = iPlainB;
          idx_d   = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = StWaitS;
`ifdef RC5_ENC_DECRYPT_EN
          dec_d   = iDecrypt;
          if (iDecrypt) begin
            idx_d  = LastIdx;
            addr_d = LastIdx;
          end
`endif
        end
      end
      StWaitS: state_d = StCompute;
      StCompute: begin
        // Odd idx updates B, even idx updates A
        if (idx_q[0]) b_d = b_new;
        else          a_d = a_new;
        if (last_idx) begin
          ca_d    = idx_q[0] ? a_q : a_new;
          cb_d    = idx_q[0] ? b_new : b_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          idx_d   = step_idx;
          addr_d  = step_idx;
          state_d = StWaitS;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      ca_q    <= '0;
      cb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RC5_ENC_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RC5_ENC_DECRYPT_EN
      dec_q   <= dec_d;
`endif
    end
  end

  assign oS_address = addr_q;
  assign oCipherA   = ca_q;
  assign oCipherB   = cb_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;

endmodule
